// File: rtl/pwm_gen.sv
// Free-running PWM generator with a microsecond time base.
//
// A prescaler divides the system clock down to 1 us ticks. A microsecond counter
// runs from 0 to per_sh-1, and the line is high while the counter is below duty_sh.
// The period and duty inputs are copied into shadow registers only at a period
// boundary, or while idle. Changes made in the middle of a period therefore
// cannot truncate or glitch the current pulse.
//
// Ports:
//   clk          - system clock, rising-edge active
//   rst          - asynchronous reset, active low
//   pwmPeriod    - PWM period in microseconds (0 = stop after the current period)
//   pwmDutyCycle - high time per period in microseconds (>= period means always high)
//   pwm          - registered PWM output
module pwm_gen #(
  parameter int unsigned CLK_PERIOD = 100,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pwmPeriod,
  input  logic [DATA_WIDTH-1:0] pwmDutyCycle,
  output logic                  pwm
);

  localparam int unsigned TicksPerUs = (CLK_PERIOD == 0) ? 1 : 1000 / CLK_PERIOD;
  localparam int unsigned PrescW     = (TicksPerUs > 1) ? $clog2(TicksPerUs) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(TicksPerUs - 1);

  if (CLK_PERIOD == 0 || CLK_PERIOD > 1000 || (1000 % CLK_PERIOD) != 0) begin : g_bad_clk_period
    $error("pwm_gen: CLK_PERIOD must divide 1000 exactly");
  end

  logic [PrescW-1:0]     presc_q, presc_d;
  logic [DATA_WIDTH-1:0] us_cnt_q, us_cnt_d;
  logic [DATA_WIDTH-1:0] per_sh_q, per_sh_d;
  logic [DATA_WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic                  pwm_q, pwm_d;

  logic idle;
  logic us_tick;

  assign idle    = (per_sh_q == '0);
  assign us_tick = (presc_q == PrescLast);

  always_comb begin
    presc_d   = presc_q;
    us_cnt_d  = us_cnt_q;
    per_sh_d  = per_sh_q;
    duty_sh_d = duty_sh_q;
    pwm_d     = 1'b0;

    if (idle) begin
      // Idle: keep sampling the inputs until a nonzero period shows up.
      presc_d   = '0;
      us_cnt_d  = '0;
      per_sh_d  = pwmPeriod;
      duty_sh_d = pwmDutyCycle;
    end else begin
      presc_d = us_tick ? '0 : presc_q + PrescW'(1);
      if (us_tick) begin
        if (us_cnt_q == per_sh_q - DATA_WIDTH'(1)) begin
          // Period boundary: the only point where new settings are accepted.
          us_cnt_d  = '0;
          per_sh_d  = pwmPeriod;
          duty_sh_d = pwmDutyCycle;
        end else begin
          us_cnt_d = us_cnt_q + DATA_WIDTH'(1);
        end
      end
      // Uses the counter value before this edge, so the line lags the counter by one clock.
      pwm_d = (us_cnt_q < duty_sh_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q   <= '0;
      us_cnt_q  <= '0;
      per_sh_q  <= '0;
      duty_sh_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      us_cnt_q  <= us_cnt_d;
      per_sh_q  <= per_sh_d;
      duty_sh_q <= duty_sh_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Testbench for pwm_gen.
// Each clock edge, a waveform model predicts the line level and pushes it into a queue.
// A monitor pops that prediction on the falling edge and compares it with the DUT.
module tb_pwm_gen;

  localparam int unsigned CLK_PERIOD = 100;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned T          = 1000 / CLK_PERIOD;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [DATA_WIDTH-1:0] pwmPeriod = '0;
  logic [DATA_WIDTH-1:0] pwmDutyCycle = '0;
  logic                  pwm;

  int n_vec = 0;
  int n_err = 0;

  bit exp_q[$];

  pwm_gen #(
    .CLK_PERIOD(CLK_PERIOD),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pwmPeriod   (pwmPeriod),
    .pwmDutyCycle(pwmDutyCycle),
    .pwm         (pwm)
  );

  always #(CLK_PERIOD / 2) clk = ~clk;

  // Model of the waveform. m_t is the clock index inside the current period.
  // A period lasts m_per*T clocks, and the line is high while m_t/T < m_duty.
  initial begin : model
    longint unsigned m_per;
    longint unsigned m_duty;
    longint unsigned m_t;
    bit e;
    m_per = 0; m_duty = 0; m_t = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_per = 0; m_duty = 0; m_t = 0;
        exp_q.delete();
      end else begin
        if (m_per == 0) begin
          e     = 1'b0;
          m_per = pwmPeriod;
          m_duty = pwmDutyCycle;
          m_t   = 0;
        end else begin
          e   = ((m_t / T) < m_duty);
          m_t = m_t + 1;
          if (m_t == m_per * T) begin
            m_t    = 0;
            m_per  = pwmPeriod;
            m_duty = pwmDutyCycle;
          end
        end
        exp_q.push_back(e);
      end
    end
  end

  initial begin : monitor
    bit e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        n_vec++;
        if (pwm !== 1'b0) begin
          n_err++;
          $display("FAIL reset_level t=%0t pwm=%b required 0", $time, pwm);
        end
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (pwm !== e) begin
          n_err++;
          $display("FAIL pwm_wave t=%0t pwm=%b required %b", $time, pwm, e);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input int unsigned p, input int unsigned d);
    pwmPeriod    = DATA_WIDTH'(p);
    pwmDutyCycle = DATA_WIDTH'(d);
  endtask

  // Drop reset mid-cycle and check that pwm falls without waiting for a clock edge.
  // Then program new settings and release reset on the next falling edge.
  task automatic async_reset(input int unsigned p, input int unsigned d);
    @(negedge clk);
    #(CLK_PERIOD / 5);
    rst = 1'b0;
    #1;
    n_vec++;
    if (pwm !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset t=%0t pwm=%b required 0", $time, pwm);
    end
    set_in(p, d);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_high(input int budget);
    int k;
    k = 0;
    while (pwm !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (pwm !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_high timeout pwm=%b required 1", pwm);
    end
  endtask

  initial begin : stim
    // Plan 1: period 2, duty 1; release reset at 200 ns.
    set_in(2, 1);
    #200;
    rst = 1'b1;
    cycles(50);

    // Plan 2: reset in the middle of a high pulse, then run period 4, duty 1.
    wait_high(40);
    async_reset(4, 1);
    cycles(100);

    // Plan 3: duty equal to the period, then duty above the period.
    async_reset(3, 3);
    cycles(80);
    async_reset(3, 7);
    cycles(80);

    // Plan 4: duty 0, then period 0. With period 0 the block must stay idle.
    async_reset(5, 0);
    cycles(120);
    async_reset(0, 3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if (dut.presc_q !== '0 || dut.us_cnt_q !== '0) begin
        n_err++;
        $display("FAIL idle_counters presc=%0d us_cnt=%0d required 0/0",
                 dut.presc_q, dut.us_cnt_q);
      end
    end

    // Plan 5: change the settings during the low phase of a period-4 run.
    async_reset(4, 1);
    cycles(25);
    set_in(2, 2);
    cycles(80);

    // Plan 6: write period 0 while running, then restart with period 2.
    async_reset(2, 1);
    cycles(25);
    set_in(0, 1);
    cycles(40);
    set_in(2, 1);
    cycles(60);

    // Random phase: random settings changes and occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) set_in($urandom_range(0, 5), $urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) async_reset($urandom_range(0, 5), $urandom_range(0, 7));
    end

    cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
